// File: rtl/popcount_seq_pkg.sv
// ---------------------------------------------------------------------------
// popcount_seq_pkg
// Definitions shared by the popcount_seq block:
//   state_e : FSM state encodings (IDLE=0, COUNT=1, DONE=2)
//   clog2   : constant ceil(log2()) helper, used for the count width and the
//             per-chunk sum width
// ---------------------------------------------------------------------------
package popcount_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/popcount_seq_chunk.sv
// ---------------------------------------------------------------------------
// popcount_chunk
// Purely combinational ones-counter over a CHUNK-bit slice.
// Ports:
//   bits_i  [CHUNK-1:0]  slice to count
//   count_o [SW-1:0]     number of set bits, SW = clog2(CHUNK+1)
// ---------------------------------------------------------------------------
module popcount_chunk
  import popcount_seq_pkg::*;
#(
  parameter  int CHUNK = 8,
  localparam int SW    = clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits_i,
  output logic [SW-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count_o = count_o + SW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// ---------------------------------------------------------------------------
// popcount_seq
// Multi-cycle ones/zeros counter. A WIDTH-bit word is accepted over a
// valid/ready handshake, counted CHUNK bits per cycle, and the count is
// returned over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   source word valid
//   in_ready   block can accept a word (high in IDLE only)
//   in_data    word to count
//   in_mode    0 = count ones, 1 = count zeros (sampled with in_data)
//   out_valid  result valid (high in DONE)
//   out_ready  consumer accepts result
//   out_count  result count
//   out_all    out_count == WIDTH
//   out_none   out_count == 0
//   out_thermo thermometer code of out_count (only with POPCOUNT_THERMO_EN)
//
// Optional feature macro: POPCOUNT_THERMO_EN adds the out_thermo port.
// ---------------------------------------------------------------------------
module popcount_seq
  import popcount_seq_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_all,
  output logic             out_none
`ifdef POPCOUNT_THERMO_EN
  ,
  output logic [WIDTH-1:0] out_thermo
`endif
);

  localparam int SW    = clog2(CHUNK + 1);
  localparam int IDX_W = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q;
  logic [CW-1:0]      acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CW-1:0]      count_q;
  logic               all_q, none_q;
  logic [CHUNK-1:0]   chunk_sel;
  logic [SW-1:0]      chunk_cnt;
  logic               last_chunk;

  // ---------------------------------------------------------------------------
  // Chunk selection and counting
  // ---------------------------------------------------------------------------
  always_comb begin
    chunk_sel = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) chunk_sel = data_q[i*CHUNK +: CHUNK];
    end
  end

  popcount_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .bits_i  (chunk_sel),
    .count_o (chunk_cnt)
  );

  // Accumulator cannot overflow: its width already holds WIDTH.
  assign acc_d      = acc_q + CW'(chunk_cnt);
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid)   state_d = ST_COUNT;
      ST_COUNT: if (last_chunk) state_d = ST_DONE;
      ST_DONE:  if (out_ready)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      all_q   <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            // Counting zeros is counting ones of the inverted word.
            data_q <= in_mode ? ~in_data : in_data;
            acc_q  <= '0;
            idx_q  <= '0;
          end
        end
        ST_COUNT: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDX_W'(1);
          if (last_chunk) begin
            count_q <= acc_d;
            all_q   <= (acc_d == CW'(WIDTH));
            none_q  <= (acc_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_count = count_q;
  assign out_all   = all_q;
  assign out_none  = none_q;

`ifdef POPCOUNT_THERMO_EN
  // Thermometer bit gi is set when the final count exceeds gi.
  logic [WIDTH-1:0] thermo_d, thermo_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_thermo
    assign thermo_d[gi] = (CW'(gi) < acc_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                               thermo_q <= '0;
    else if (state_q == ST_COUNT && last_chunk) thermo_q <= thermo_d;
  end

  assign out_thermo = thermo_q;
`endif

endmodule

// File: tb/tb_popcount_seq.sv
// ---------------------------------------------------------------------------
// tb_popcount_seq
// Directed bench for popcount_seq with WIDTH=32, CHUNK=8.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_popcount_seq;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int CW    = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_all;
  logic             out_none;
`ifdef POPCOUNT_THERMO_EN
  logic [WIDTH-1:0] out_thermo;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  popcount_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_all    (out_all),
    .out_none   (out_none)
`ifdef POPCOUNT_THERMO_EN
    ,
    .out_thermo (out_thermo)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_count !== 6'd0) begin tests_failed++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    tests_run++;
    if (out_all !== 1'b0) begin tests_failed++; $display("FAIL reset_out_all: got %b expected 0", out_all); end
    tests_run++;
    if (out_none !== 1'b0) begin tests_failed++; $display("FAIL reset_out_none: got %b expected 0", out_none); end
    rst_n = 1'b1;
    $display("[TB] reset: in_ready=%b out_valid=%b out_count=%0d", in_ready, out_valid, out_count);
  endtask

  // One word with out_ready held high: checks latency, result, and return to IDLE.
  task automatic test_word(input logic [31:0] d, input logic m, input int exp_cnt,
                           input logic exp_all, input logic exp_none,
                           input logic [31:0] exp_thermo, input string tag);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    out_ready = 1'b1;
    @(posedge clk);            // accept edge k
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("FAIL %s_latency: got %0d expected 4", tag, lat); end
    tests_run++;
    if (out_count !== CW'(exp_cnt)) begin tests_failed++; $display("FAIL %s_count: got %0d expected %0d", tag, out_count, exp_cnt); end
    tests_run++;
    if (out_all !== exp_all) begin tests_failed++; $display("FAIL %s_all: got %b expected %b", tag, out_all, exp_all); end
    tests_run++;
    if (out_none !== exp_none) begin tests_failed++; $display("FAIL %s_none: got %b expected %b", tag, out_none, exp_none); end
`ifdef POPCOUNT_THERMO_EN
    tests_run++;
    if (out_thermo !== exp_thermo) begin tests_failed++; $display("FAIL %s_thermo: got %h expected %h", tag, out_thermo, exp_thermo); end
`else
    if (exp_thermo === 32'hx) $display("[TB] unused thermo");
`endif
    @(negedge clk);            // edge k+5: back in IDLE
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_release: got valid=%b ready=%b expected valid=0 ready=1", tag, out_valid, in_ready);
    end
    tests_run++;
    if (out_count !== CW'(exp_cnt)) begin tests_failed++; $display("FAIL %s_count_hold: got %0d expected %0d", tag, out_count, exp_cnt); end
    $display("[TB] %s: data=%h mode=%b count=%0d all=%b none=%b latency=%0d", tag, d, m, out_count, out_all, out_none, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h0F0F_0F0F;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    // Hold off the consumer for 5 cycles while the source pushes another word.
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 6'd16) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d bad cycles expected 0 (count=%0d)", bad, out_count); end
`ifdef POPCOUNT_THERMO_EN
    tests_run++;
    if (out_thermo !== 32'h0000_FFFF) begin tests_failed++; $display("FAIL bp_thermo: got %h expected 0000ffff", out_thermo); end
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 6'd16) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b ready=%b count=%0d expected valid=0 ready=1 count=16", out_valid, in_ready, out_count);
    end
    $display("[TB] backpressure: data=0f0f0f0f count=%0d held 5 cycles", out_count);
  endtask

  task automatic test_reset_mid_count();
    int seen;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);            // accept edge k
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);            // edge k+1 done; next edge is the second COUNT edge
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 6'd0) begin
      tests_failed++;
      $display("FAIL midrst_state: got ready=%b valid=%b count=%0d expected ready=1 valid=0 count=0", in_ready, out_valid, out_count);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen); end
    $display("[TB] reset mid-count: word discarded, valid cycles=%0d", seen);
  endtask

  initial begin
    test_reset();
    test_word(32'hFFFF_FFFF, 1'b0, 32, 1'b1, 1'b0, 32'hFFFF_FFFF, "ones_all");
    test_word(32'h8000_0001, 1'b1, 30, 1'b0, 1'b0, 32'h3FFF_FFFF, "zeros_edges");
    test_word(32'h0000_0000, 1'b0, 0,  1'b0, 1'b1, 32'h0000_0000, "ones_none");
    test_word(32'h0000_0000, 1'b1, 32, 1'b1, 1'b0, 32'hFFFF_FFFF, "zeros_all");
    test_backpressure();
    test_reset_mid_count();
    test_word(32'h0000_0007, 1'b0, 3,  1'b0, 1'b0, 32'h0000_0007, "after_reset");
    test_word(32'h0000_00F0, 1'b0, 4,  1'b0, 1'b0, 32'h0000_000F, "thermo_f0");
    test_word(32'h1234_5678, 1'b0, 13, 1'b0, 1'b0, 32'h0000_1FFF, "mixed");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
